sevenseg_scan_ctrl: RTL and testbench

Memory-mapped, parametrised multiplexed 7-segment display controller for the IO region next to the UART.
- Drives NUM_DIGITS common-select lines and one shared 8-bit segment bus, time-multiplexed.
- Adds full hex glyphs, per-digit decimal point and digit mask, PWM brightness, and inter-digit ghost blanking.
- Polarity of both the segment and common outputs is configurable.
- Register access uses the same valid/addr/wdata/wstrb bus as the other IO peripherals, with byte strobes.

---
 rtl/sevenseg_scan_ctrl.sv | 176 +++++++++++++++++
 tb/tb_sevenseg_scan_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed 7-segment display controller with a byte-strobed register interface.
// Scans NUM_DIGITS commons over a shared segment bus with PWM dimming and ghost blanking.
module sevenseg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS     = 2,
    parameter int unsigned SCAN_DIV       = 65536,
    parameter int unsigned BLANK_CYCLES   = 256,
    parameter bit          COM_ACTIVE_LOW = 1'b0,
    parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid,
    input  logic [2:0]            addr,
    input  logic [31:0]           wdata,
    input  logic [3:0]            wstrb,
    output logic [31:0]           rdata,
    output logic [7:0]            seg_o,
    output logic [NUM_DIGITS-1:0] com_o
);

    localparam int unsigned SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [31:0] DATA_MASK =
        (NUM_DIGITS >= 8) ? 32'hFFFF_FFFF : ((32'd1 << (4 * NUM_DIGITS)) - 32'd1);
    localparam logic [31:0] DIG_MASK   = (32'd1 << NUM_DIGITS) - 32'd1;
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
    localparam logic [SLOT_W-1:0] BLANK_END  = SLOT_W'(BLANK_CYCLES);
    localparam logic [2:0]        DIGIT_LAST = 3'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] COM_ONE = 1;

    logic [31:0]           data_q, data_d, dp_q, dp_d, mask_q, mask_d;
    logic [1:0]            ctrl_q, ctrl_d;
    logic [7:0]            bright_q, bright_d;
    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic [2:0]            digit_q, digit_d;
    logic [15:0]           frame_q, frame_d;
    logic [7:0]            pwm_q;
    logic [31:0]           rdata_q;
    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] com_q, com_d;

    logic [31:0] reg_view, wr_merged;
    logic        wr_en, rd_en, lit;
    logic [3:0]  nib;
    logic [7:0]  glyph_raw;

    function automatic logic [7:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 8'hFC;
            4'h1: glyph = 8'h60;
            4'h2: glyph = 8'hDA;
            4'h3: glyph = 8'hF2;
            4'h4: glyph = 8'h66;
            4'h5: glyph = 8'hB6;
            4'h6: glyph = 8'hBE;
            4'h7: glyph = 8'hE0;
            4'h8: glyph = 8'hFE;
            4'h9: glyph = 8'hF6;
            4'hA: glyph = 8'hEE;
            4'hB: glyph = 8'h3E;
            4'hC: glyph = 8'h9C;
            4'hD: glyph = 8'h7A;
            4'hE: glyph = 8'h9E;
            default: glyph = 8'h8E;
        endcase
    endfunction

    assign wr_en = valid && (wstrb != 4'b0000);
    assign rd_en = valid && (wstrb == 4'b0000);

    always_comb begin
        case (addr)
            3'd0:    reg_view = data_q;
            3'd1:    reg_view = {30'b0, ctrl_q};
            3'd2:    reg_view = dp_q;
            3'd3:    reg_view = mask_q;
            3'd4:    reg_view = {24'b0, bright_q};
            3'd5:    reg_view = {frame_q, 13'b0, digit_q};
            default: reg_view = 32'b0;
        endcase
    end

    always_comb begin
        wr_merged = reg_view;
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) wr_merged[8*b +: 8] = wdata[8*b +: 8];
        end
    end

    always_comb begin
        data_d   = data_q;
        ctrl_d   = ctrl_q;
        dp_d     = dp_q;
        mask_d   = mask_q;
        bright_d = bright_q;
        if (wr_en) begin
            case (addr)
                3'd0:    data_d   = wr_merged & DATA_MASK;
                3'd1:    ctrl_d   = wr_merged[1:0];
                3'd2:    dp_d     = wr_merged & DIG_MASK;
                3'd3:    mask_d   = wr_merged & DIG_MASK;
                3'd4:    bright_d = wr_merged[7:0];
                default: ;
            endcase
        end
    end

    // Scan position is pinned at digit 0, slot 0 while disabled.
    always_comb begin
        slot_d  = slot_q;
        digit_d = digit_q;
        frame_d = frame_q;
        if (!ctrl_q[0]) begin
            slot_d  = '0;
            digit_d = 3'd0;
            frame_d = 16'd0;
        end else if (slot_q == SLOT_LAST) begin
            slot_d = '0;
            if (digit_q == DIGIT_LAST) begin
                digit_d = 3'd0;
                frame_d = frame_q + 16'd1;
            end else begin
                digit_d = digit_q + 3'd1;
            end
        end else begin
            slot_d = slot_q + 1'b1;
        end
    end

    always_comb begin
        nib       = data_q[{digit_q, 2'b00} +: 4];
        glyph_raw = glyph(nib);
        lit       = ctrl_q[0] && mask_q[digit_q] && (slot_q >= BLANK_END) && (pwm_q < bright_q);
        seg_d     = 8'h00;
        com_d     = '0;
        if (lit) begin
            com_d = COM_ONE << digit_q;
            if (ctrl_q[1] && (nib > 4'd9)) seg_d = 8'h01;
            else                           seg_d = {glyph_raw[7:1], dp_q[digit_q]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q   <= 32'b0;
            ctrl_q   <= 2'b0;
            dp_q     <= 32'b0;
            mask_q   <= DIG_MASK;
            bright_q <= 8'hFF;
            slot_q   <= '0;
            digit_q  <= 3'd0;
            frame_q  <= 16'd0;
            pwm_q    <= 8'd0;
            rdata_q  <= 32'b0;
            seg_q    <= 8'h00;
            com_q    <= '0;
        end else begin
            data_q   <= data_d;
            ctrl_q   <= ctrl_d;
            dp_q     <= dp_d;
            mask_q   <= mask_d;
            bright_q <= bright_d;
            slot_q   <= slot_d;
            digit_q  <= digit_d;
            frame_q  <= frame_d;
            pwm_q    <= pwm_q + 8'd1;
            if (rd_en) rdata_q <= reg_view;
            seg_q    <= seg_d;
            com_q    <= com_d;
        end
    end

    assign rdata = rdata_q;
    assign seg_o = seg_q ^ {8{SEG_ACTIVE_LOW}};
    assign com_o = com_q ^ {NUM_DIGITS{COM_ACTIVE_LOW}};

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Bench for sevenseg_scan_ctrl: register vectors, a per-cycle output scoreboard and
// hand-written multi-cycle scan sequences on a 4-digit, 16-cycle-slot configuration.
module tb_sevenseg_scan_ctrl;

    localparam int ND = 4;
    localparam int SD = 16;
    localparam int BC = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid = 1'b0;
    logic [2:0]  addr = 3'd0;
    logic [31:0] wdata = 32'd0;
    logic [3:0]  wstrb = 4'd0;
    logic [31:0] rdata, rdata_lo;
    logic [7:0]  seg, seg_lo;
    logic [3:0]  com, com_lo;

    sevenseg_scan_ctrl #(
        .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC),
        .COM_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .valid(valid), .addr(addr), .wdata(wdata),
        .wstrb(wstrb), .rdata(rdata), .seg_o(seg), .com_o(com)
    );

    sevenseg_scan_ctrl #(
        .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC),
        .COM_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b0)
    ) dut_lo (
        .clk(clk), .reset(reset), .valid(valid), .addr(addr), .wdata(wdata),
        .wstrb(wstrb), .rdata(rdata_lo), .seg_o(seg_lo), .com_o(com_lo)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] seg;
        logic [3:0] com;
    } out_t;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [7:0] glyph_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                   8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

    // Shadow registers and reference scan state
    logic [31:0] s_data = 0, s_dp = 0, s_mask = 32'hF;
    logic [1:0]  s_ctrl = 0;
    logic [7:0]  s_bright = 8'hFF;
    int          m_slot = 0, m_digit = 0;
    logic [15:0] m_frame = 0;
    logic [7:0]  m_pwm = 0;

    out_t        exp_q[$];
    logic [31:0] rd_q[$];
    bit          rd_pending = 0;
    logic [31:0] last_rd = 0;

    bit          cap_on = 0;
    int          lit_cnt [4];
    logic [7:0]  cap_seg [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 20) $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic clear_caps();
        for (int d = 0; d < 4; d++) begin
            lit_cnt[d] = 0;
            cap_seg[d] = 8'h00;
        end
    endtask

    task automatic step();
        out_t       e;
        logic [3:0] nib;
        e = '0;
        if (!reset && s_ctrl[0] && s_mask[m_digit] && m_slot >= BC && m_pwm < s_bright) begin
            nib   = s_data[4*m_digit +: 4];
            e.com = 4'(1 << m_digit);
            if (s_ctrl[1] && nib > 4'd9) e.seg = 8'h01;
            else                         e.seg = glyph_tab[nib] | {7'b0, s_dp[m_digit]};
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("seg_o", {24'b0, seg}, {24'b0, e.seg});
        check("com_o", {28'b0, com}, {28'b0, e.com});
        check("low_pol_outputs", {20'b0, seg_lo, com_lo}, {20'b0, e.seg, ~e.com});
        if (reset)           last_rd = 32'd0;
        else if (rd_pending) last_rd = rd_q.pop_front();
        check("rdata", rdata, last_rd);
        check("rdata_lo", rdata_lo, last_rd);
        if (cap_on) begin
            for (int d = 0; d < 4; d++) begin
                if (com == 4'(1 << d)) begin
                    lit_cnt[d]++;
                    cap_seg[d] = seg;
                end
            end
        end
        if (reset) begin
            s_data = 0; s_dp = 0; s_mask = 32'hF; s_ctrl = 0; s_bright = 8'hFF;
            m_slot = 0; m_digit = 0; m_frame = 0; m_pwm = 0;
        end else begin
            m_pwm++;
            if (!s_ctrl[0]) begin
                m_slot = 0; m_digit = 0; m_frame = 0;
            end else if (m_slot == SD - 1) begin
                m_slot = 0;
                if (m_digit == ND - 1) begin
                    m_digit = 0;
                    m_frame++;
                end else begin
                    m_digit++;
                end
            end else begin
                m_slot++;
            end
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m;
        valid = 1'b1; addr = a; wdata = d; wstrb = s;
        step();
        valid = 1'b0; wstrb = 4'd0;
        case (a)
            3'd0: s_data = merge(s_data, d, s) & 32'h0000FFFF;
            3'd1: begin m = merge({30'b0, s_ctrl}, d, s); s_ctrl = m[1:0]; end
            3'd2: s_dp = merge(s_dp, d, s) & 32'hF;
            3'd3: s_mask = merge(s_mask, d, s) & 32'hF;
            3'd4: begin m = merge({24'b0, s_bright}, d, s); s_bright = m[7:0]; end
            default: ;
        endcase
    endtask

    task automatic bus_read(input logic [2:0] a, input logic [31:0] exp);
        valid = 1'b1; addr = a; wstrb = 4'd0;
        rd_q.push_back(exp);
        rd_pending = 1'b1;
        step();
        rd_pending = 1'b0;
        valid = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) step();
        reset = 1'b0;
    endtask

    vec_t vecs [16];

    initial begin
        int         total;
        int         guard;
        bit         found;
        logic [7:0] exp_seg [4];

        vecs = '{
            '{3'd1, 32'h0,        4'b0000, 32'h0},
            '{3'd3, 32'h0,        4'b0000, 32'hF},
            '{3'd4, 32'h0,        4'b0000, 32'hFF},
            '{3'd0, 32'h0,        4'b0000, 32'h0},
            '{3'd6, 32'h0,        4'b0000, 32'h0},
            '{3'd0, 32'hFFFFFFFF, 4'b0010, 32'h0000FF00},
            '{3'd0, 32'h12345678, 4'b1111, 32'h00005678},
            '{3'd2, 32'hFFFFFFFF, 4'b0001, 32'hF},
            '{3'd3, 32'h0,        4'b1111, 32'h0},
            '{3'd3, 32'hFFFFFF0A, 4'b0001, 32'hA},
            '{3'd4, 32'hABCD1234, 4'b0110, 32'hFF},
            '{3'd4, 32'h00000040, 4'b0001, 32'h40},
            '{3'd6, 32'hDEADBEEF, 4'b1111, 32'h0},
            '{3'd7, 32'hDEADBEEF, 4'b1111, 32'h0},
            '{3'd5, 32'hFFFFFFFF, 4'b1111, 32'h0},
            '{3'd1, 32'h000000FC, 4'b0001, 32'h0}
        };

        do_reset(3);
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].wstrb != 4'b0000) bus_write(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
            bus_read(vecs[i].addr, vecs[i].exp);
        end
        repeat (3) step();

        // Full hex frame at 255/256 duty; pwm stays well below 255 in this window.
        do_reset(2);
        bus_write(3'd0, 32'h0000A931, 4'hF);
        bus_write(3'd1, 32'h1, 4'h1);
        clear_caps();
        cap_on = 1;
        repeat (64) step();
        cap_on = 0;
        exp_seg = '{8'h60, 8'hF2, 8'hF6, 8'hEE};
        for (int d = 0; d < 4; d++) begin
            check($sformatf("lit_cycles_d%0d", d), lit_cnt[d], 14);
            check($sformatf("glyph_d%0d", d), {24'b0, cap_seg[d]}, {24'b0, exp_seg[d]});
        end
        bus_read(3'd5, 32'h00010000);

        // Legacy mode, decimal point and digit mask together
        bus_write(3'd1, 32'h3, 4'h1);
        bus_write(3'd2, 32'h2, 4'h1);
        bus_write(3'd3, 32'hB, 4'h1);
        clear_caps();
        cap_on = 1;
        repeat (64) step();
        cap_on = 0;
        check("legacy_d0", {24'b0, cap_seg[0]}, 32'h60);
        check("dp_d1", {24'b0, cap_seg[1]}, 32'hF3);
        check("legacy_d3", {24'b0, cap_seg[3]}, 32'h01);
        check("masked_d2_lit", lit_cnt[2], 0);
        check("lit_cycles_d3", lit_cnt[3], 14);

        // PWM duty: 64 of 256 pwm values, minus two blank cycles per 16-cycle slot
        bus_write(3'd3, 32'hF, 4'h1);
        bus_write(3'd1, 32'h1, 4'h1);
        bus_write(3'd4, 32'h40, 4'h1);
        clear_caps();
        cap_on = 1;
        repeat (256) step();
        cap_on = 0;
        total = lit_cnt[0] + lit_cnt[1] + lit_cnt[2] + lit_cnt[3];
        check("bright40_lit", total, 56);
        bus_write(3'd4, 32'h0, 4'h1);
        clear_caps();
        cap_on = 1;
        repeat (256) step();
        cap_on = 0;
        total = lit_cnt[0] + lit_cnt[1] + lit_cnt[2] + lit_cnt[3];
        check("bright0_lit", total, 0);

        // Reset in the middle of digit 2's slot
        bus_write(3'd4, 32'hFF, 4'h1);
        guard = 0;
        while (!(m_digit == 2 && m_slot == 5) && guard < 200) begin
            step();
            guard++;
        end
        check("reach_digit2_in_time", guard < 200, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("reset_com_lo", {28'b0, com_lo}, 32'hF);
        check("reset_seg_lo", {24'b0, seg_lo}, 32'h0);
        bus_read(3'd5, 32'h0);
        bus_read(3'd1, 32'h0);
        bus_write(3'd1, 32'h1, 4'h1);
        found = 0;
        guard = 0;
        while (!found && guard < 40) begin
            step();
            guard++;
            if (com != 4'b0000) found = 1;
        end
        check("restart_lit_seen", found, 1);
        check("restart_first_digit", {28'b0, com}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
